// File: rtl/candy_div_pkg.sv
// candy_div_pkg: shared constants, FSM state encoding and small helpers for
// the multi-cycle divider.
//   RegBus            datapath width (operand, quotient, remainder)
//   ZeroWord          all-zero datapath word
//   DivStart/DivStop  values of the ALU's start request
//   DivResultReady/DivResultNotReady  values of the ready response
//   div_state_t       DivFree / DivByZero / DivOn / DivEnd
package candy_div_pkg;

    localparam int RegBus = 24;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    // Two's-complement negate when en is set, pass through otherwise.
    function automatic logic [RegBus-1:0] negate_if(input logic [RegBus-1:0] value,
                                                    input logic en);
        negate_if = en ? (ZeroWord - value) : value;
    endfunction

endpackage

// File: rtl/candy_div_step.sv
// candy_div_step: one combinational iteration of restoring division.
//   partial_rem   in   WIDTH+1  partial remainder from the previous iteration
//   dividend_bit  in   1        next dividend bit (MSB first)
//   divisor       in   WIDTH    divisor magnitude
//   new_rem       out  WIDTH+1  partial remainder after this iteration
//   quot_bit      out  1        quotient bit produced by this iteration
module candy_div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH:0]   partial_rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   new_rem,
    output logic             quot_bit
);

    // The partial remainder is always below the divisor, so after the shift
    // it fits in WIDTH+1 bits; one more bit holds the sign of the trial
    // subtraction.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted  = {partial_rem, dividend_bit};
        diff     = shifted - {2'b00, divisor};
        quot_bit = ~diff[WIDTH+1];
        new_rem  = quot_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/candy_div.sv
// candy_div: multi-cycle signed/unsigned integer divider, one quotient bit
// per clock. Responder on the ALU divide handshake: the ALU holds start_i
// high until it sees ready_o, then drops start_i to release the result.
//   clk           in   1      clock, rising edge
//   rst           in   1      asynchronous reset, active low
//   signed_div_i  in   1      1 = two's-complement divide, 0 = unsigned
//   opdata1_i     in   WIDTH  dividend
//   opdata2_i     in   WIDTH  divisor
//   start_i       in   1      divide request, held high until released
//   annul_i       in   1      abort (pipeline flush)
//   result_o      out  WIDTH  quotient
//   rem_o         out  WIDTH  remainder
//   ready_o       out  1      result valid
module candy_div
    import candy_div_pkg::*;
#(
    parameter int WIDTH = RegBus
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             start_i,
    input  logic             annul_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             ready_o
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] dividend_raw_reg, dividend_raw_next;  // as presented, for /0
    logic [WIDTH-1:0] dividend_reg, dividend_next;          // magnitude, shifted out MSB first
    logic [WIDTH-1:0] divisor_reg, divisor_next;            // magnitude
    logic [WIDTH:0]   part_rem_reg, part_rem_next;
    logic [WIDTH-2:0] quot_reg, quot_next;                  // quotient bits so far
    logic             neg_quot_reg, neg_quot_next;
    logic             neg_rem_reg, neg_rem_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic             ready_reg, ready_next;

    logic [WIDTH:0]   step_rem;
    logic             step_quot_bit;
    logic [WIDTH-1:0] quot_full;
    logic             abort;
    logic             neg_dividend;
    logic             neg_divisor;

    candy_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .partial_rem  (part_rem_reg),
        .dividend_bit (dividend_reg[WIDTH-1]),
        .divisor      (divisor_reg),
        .new_rem      (step_rem),
        .quot_bit     (step_quot_bit)
    );

    assign quot_full    = {quot_reg, step_quot_bit};
    assign abort        = (start_i == DivStop) || annul_i;
    assign neg_dividend = signed_div_i & opdata1_i[WIDTH-1];
    assign neg_divisor  = signed_div_i & opdata2_i[WIDTH-1];

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        dividend_raw_next = dividend_raw_reg;
        dividend_next     = dividend_reg;
        divisor_next      = divisor_reg;
        part_rem_next     = part_rem_reg;
        quot_next         = quot_reg;
        neg_quot_next     = neg_quot_reg;
        neg_rem_next      = neg_rem_reg;
        result_next       = result_reg;
        rem_next          = rem_reg;
        ready_next        = ready_reg;

        case (state_reg)
            DivFree: begin
                // A simultaneous annul cancels the request before it is taken.
                if (start_i == DivStart && !annul_i) begin
                    dividend_raw_next = opdata1_i;
                    if (opdata2_i == ZeroWord) begin
                        state_next = DivByZero;
                    end else begin
                        dividend_next = negate_if(opdata1_i, neg_dividend);
                        divisor_next  = negate_if(opdata2_i, neg_divisor);
                        neg_quot_next = neg_dividend ^ neg_divisor;
                        neg_rem_next  = neg_dividend;
                        part_rem_next = '0;
                        quot_next     = '0;
                        cnt_next      = '0;
                        state_next    = DivOn;
                    end
                end
            end

            DivByZero: begin
                if (abort) begin
                    state_next = DivFree;
                end else begin
                    result_next = '1;
                    rem_next    = dividend_raw_reg;
                    ready_next  = DivResultReady;
                    state_next  = DivEnd;
                end
            end

            DivOn: begin
                if (abort) begin
                    state_next = DivFree;
                end else begin
                    dividend_next = dividend_reg << 1;
                    part_rem_next = step_rem;
                    quot_next     = quot_full[WIDTH-2:0];
                    cnt_next      = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        // Sign fix-up on the last iteration. The most-negative
                        // by -1 case falls out naturally as a wrap to itself.
                        result_next = negate_if(quot_full, neg_quot_reg);
                        rem_next    = negate_if(step_rem[WIDTH-1:0], neg_rem_reg);
                        ready_next  = DivResultReady;
                        state_next  = DivEnd;
                    end
                end
            end

            DivEnd: begin
                if (abort) begin
                    result_next = ZeroWord;
                    rem_next    = ZeroWord;
                    ready_next  = DivResultNotReady;
                    state_next  = DivFree;
                end
            end

            default: begin
                state_next = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= DivFree;
            cnt_reg          <= '0;
            dividend_raw_reg <= '0;
            dividend_reg     <= '0;
            divisor_reg      <= '0;
            part_rem_reg     <= '0;
            quot_reg         <= '0;
            neg_quot_reg     <= 1'b0;
            neg_rem_reg      <= 1'b0;
            result_reg       <= ZeroWord;
            rem_reg          <= ZeroWord;
            ready_reg        <= DivResultNotReady;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            dividend_raw_reg <= dividend_raw_next;
            dividend_reg     <= dividend_next;
            divisor_reg      <= divisor_next;
            part_rem_reg     <= part_rem_next;
            quot_reg         <= quot_next;
            neg_quot_reg     <= neg_quot_next;
            neg_rem_reg      <= neg_rem_next;
            result_reg       <= result_next;
            rem_reg          <= rem_next;
            ready_reg        <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign rem_o    = rem_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_candy_div.sv
// tb_candy_div: randomized and directed stimulus against a plain-arithmetic
// reference; expected results are queued at issue time and checked by an
// independent monitor when ready_o rises.
module tb_candy_div;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         signed_div_i = 1'b0;
    logic [W-1:0] opdata1_i = '0;
    logic [W-1:0] opdata2_i = '0;
    logic         start_i = 1'b0;
    logic         annul_i = 1'b0;
    logic [W-1:0] result_o;
    logic [W-1:0] rem_o;
    logic         ready_o;

    candy_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .rem_o        (rem_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
        int           start_cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, req);
        end
    endtask

    // Reference: C-style truncating division on sign-extended integers.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        longint sa, sb_v;
        e.start_cyc = 0;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.lat = 2;
        end else begin
            if (s) begin
                sa   = longint'($signed(a));
                sb_v = longint'($signed(b));
            end else begin
                sa   = longint'({40'd0, a});
                sb_v = longint'({40'd0, b});
            end
            e.q   = W'(sa / sb_v);
            e.r   = W'(sa % sb_v);
            e.lat = W + 1;
        end
        return e;
    endfunction

    // Monitor: checks every rising ready_o against the scoreboard head and
    // checks that results stay stable while ready_o is held.
    logic         ready_prev = 1'b0;
    logic [W-1:0] held_q, held_r;
    always @(negedge clk) begin
        if (rst && ready_o && !ready_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no result", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", result_o, e.q);
                check("remainder", rem_o, e.r);
                check("latency", W'(cyc - e.start_cyc), W'(e.lat));
                $display("result: q=0x%06h r=0x%06h latency=%0d", result_o, rem_o, cyc - e.start_cyc);
            end
            held_q = result_o;
            held_r = rem_o;
        end else if (rst && ready_o && ready_prev) begin
            check("hold_quotient", result_o, held_q);
            check("hold_remainder", rem_o, held_r);
        end
        ready_prev = rst ? ready_o : 1'b0;
    end

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
        exp_t e;
        bit   got;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        e = model(a, b, s);
        e.start_cyc = cyc;
        sb.push_back(e);
        $display("issue: a=0x%06h b=0x%06h signed=%0d", a, b, s);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            // Operands may wander after the latch cycle without effect.
            opdata1_i    = W'($urandom);
            opdata2_i    = W'($urandom);
            signed_div_i = 1'($urandom);
            if (ready_o) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout: got ready=0 after 40 cycles expected ready=1");
        end
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("release_ready", W'(ready_o), W'(0));
        check("release_quotient", result_o, '0);
        check("release_remainder", rem_o, '0);
    endtask

    task automatic expect_idle(input string name, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        check(name, W'(seen), W'(0));
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_ready", W'(ready_o), W'(0));
        check("reset_quotient", result_o, '0);
        check("reset_remainder", rem_o, '0);
        @(negedge clk);
        rst = 1'b1;

        do_div(24'd100, 24'd7, 1'b0, 3);
        do_div(24'hFFFF9C, 24'd7, 1'b1, 1);
        do_div(24'd100, 24'hFFFFF9, 1'b1, 0);
        do_div(24'h0004D2, 24'd0, 1'b0, 2);

        // Abort in cycle 10 of a divide
        @(negedge clk);
        opdata1_i = 24'd5000; opdata2_i = 24'd3; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        expect_idle("abort_no_ready", 35);

        // Start and annul together are not accepted
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        expect_idle("start_annul_no_ready", 30);

        do_div(24'h000010, 24'h000004, 1'b0, 0);
        do_div(24'h800000, 24'hFFFFFF, 1'b1, 0);
        do_div(24'h800000, 24'hFFFFFF, 1'b0, 0);

        // Reset in cycle 12 of a divide
        @(negedge clk);
        opdata1_i = 24'd999; opdata2_i = 24'd5; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (12) @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        #1;
        check("midreset_ready", W'(ready_o), W'(0));
        check("midreset_quotient", result_o, '0);
        check("midreset_remainder", rem_o, '0);
        @(negedge clk);
        rst = 1'b1;
        do_div(24'd12345, 24'd67, 1'b0, 0);

        // Randomized back-to-back operation
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom >> $urandom_range(0, 23));
            do_div(a, b, 1'($urandom), $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/candy_div.md
# candy_div

Multi-cycle 24-bit integer divider for the execute stage. It is the responder on the ALU's divide handshake: it accepts operands plus `start_i`/`signed_div_i`, iterates one quotient bit per clock, and returns quotient, remainder and `ready_o`. The ALU holds `start_i` high and stalls the pipeline until it sees `ready_o`.

## Interface
- `WIDTH`, 24: operand, quotient and remainder width. It must equal `RegBus`.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `signed_div_i`  in  1  1 = two's-complement divide; 0 = unsigned divide.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `start_i`  in  1  `DivStart`/`DivStop` request from the ALU.
- `annul_i`  in  1  abort request from pipeline flush.
- `result_o`  out  WIDTH  quotient. Reset value 0.
- `rem_o`  out  WIDTH  remainder. Reset value 0.
- `ready_o`  out  1  `DivResultReady`/`DivResultNotReady`. Reset value 0.

## Operation
- FSM states: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- **DivFree**
  - If `start_i` is high and `annul_i` is low, latch `signed_div_i` and both operands.
  - If the divisor is 0, go to DivByZero.
  - Otherwise, for a signed divide, store the operand magnitudes (two's-complement negate any operand with MSB = 1). Store the sign flags. Clear the counter. Go to DivOn.
- **DivByZero**
  - Set quotient to all ones and remainder to the latched dividend.
  - Go to DivEnd.
- **DivOn**: restoring division.
  - Partial remainder is WIDTH+1 bits. Each cycle, shift in the next dividend bit (MSB first).
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit 1; else restore and set quotient bit 0.
  - The counter runs 0..WIDTH-1. After the iteration with counter = WIDTH-1:
    - Negate the quotient if the divisor and dividend signs differ.
    - Negate the remainder if the dividend was negative.
    - Register `result_o`/`rem_o`, set `ready_o`, and go to DivEnd.
- **DivEnd**
  - Hold `ready_o`=1 and the results stable while `start_i` stays high.
  - When `start_i` is low, go to DivFree. Next cycle `ready_o`=0 and `result_o`=`rem_o`=0.
- **Abort**
  - `annul_i` high in DivOn or DivByZero → DivFree next cycle, `ready_o` stays 0.
  - `start_i` low in those states also aborts.
  - `annul_i` in DivEnd behaves as `start_i` low.
- **Overflow**: signed 0x800000 / 0xFFFFFF wraps. Quotient = 0x800000, remainder = 0. No flag.
- Operand changes after the latch cycle are ignored.

## Timing
- Latency is counted from the DivFree cycle in which `start_i` is sampled (cycle 0):
  - Normal divide: `ready_o` is high in cycle WIDTH+1 (25).
  - Divide by zero: `ready_o` is high in cycle 2.
- Back-to-back operation: after DivEnd→DivFree, a new start can be accepted in the next cycle. Minimum turnaround is WIDTH+3 cycles per divide.
- Reset asserted mid-operation:
  - Immediately clears the FSM to DivFree, `ready_o` to 0 and both results to 0.
  - The counter and working registers clear to 0.
- `start_i` and `annul_i` both high in DivFree: the start is not accepted.

## Structure
- `defines.v` holds the shared constants:
  - `DivFree` = 2'b00, `DivByZero` = 2'b01, `DivOn` = 2'b10, `DivEnd` = 2'b11.
  - `DivStart`/`DivStop`, `DivResultReady`/`DivResultNotReady`.
  - `RegBus`, `ZeroWord`.
- Optional sub-module `candy_div_step`: the combinational single iteration. It takes partial remainder, next dividend bit and divisor, and returns the new partial remainder and quotient bit.
- The FSM, counter and sign fix-up stay in `candy_div`.

## Test plan
- Unsigned 100 / 7 → `ready_o` rises in cycle 25, `result_o`=14, `rem_o`=2; results hold while `start_i` stays high.
- Signed 0xFFFF9C (-100) / 7 → `result_o`=0xFFFFF2 (-14), `rem_o`=0xFFFFFE (-2). Signed 100 / 0xFFFFF9 (-7) → `result_o`=0xFFFFF2, `rem_o`=2.
- Divide-by-zero 0x0004D2 / 0 → `ready_o` in cycle 2, `result_o`=0xFFFFFF, `rem_o`=0x0004D2.
- Abort and restart:
  - `annul_i` pulsed in cycle 10 of a divide → `ready_o` never rises, FSM returns to DivFree.
  - A following 0x000010 / 0x000004 → `result_o`=4, `rem_o`=0.
- 0x800000 / 0xFFFFFF:
  - Signed → `result_o`=0x800000, `rem_o`=0.
  - Unsigned → `result_o`=0, `rem_o`=0x800000.
- Handshake release and reset:
  - Drop `start_i` in DivEnd → `ready_o`=0 and results 0 the next cycle.
  - Assert `rst` low in cycle 12 of a divide → all outputs 0 immediately. After release, a new divide completes correctly.
